tdm_demux: RTL and testbench
============================

# tdm_demux

Time-division demultiplexer, the receive end of the rotating-select 4:1 mux path. A serial stream carries one sample per slot, and the slot index advances on every accepted sample. The block locks to a frame-sync marker and tracks the slot with an internal counter. It steers each sample into a per-channel capture register and publishes a complete, coherent frame on a parallel output bus. It sits between the serial link and the parallel channel consumers.

## Interface
- `NUM_CH`, default 4: channels per frame; must be ≥2.
- `DATA_W`, default 1: bits per sample.
- `SEL_W`, default `$clog2(NUM_CH)`: slot counter width; derived, never overridden.
- `clk` in 1: single clock; all logic on posedge.
- `reset` in 1: synchronous, active-high.
- `din` in `DATA_W`: serial sample.
- `din_valid` in 1: `din` is accepted on this edge.
- `sync` in 1: qualified by `din_valid`; marks the slot-0 sample.
- `dout` out `NUM_CH*DATA_W`: last complete frame; channel k at bits `[k*DATA_W +: DATA_W]`.
- `frame_valid` out 1: one-cycle pulse when `dout` updates.
- `ch_strobe` out `NUM_CH`: one-hot pulse marking which capture register was written.
- `sel` out `SEL_W`: slot index the next accepted sample will fill.
- `locked` out 1: high in `LOCKED`.
- `sync_err` out 1: one-cycle misalignment pulse (see Configuration).

## Operation
- FSM has two states: `HUNT` and `LOCKED`.
- **`HUNT`:**
  - Samples without `sync` are discarded; `ch_strobe` stays 0.
  - On `din_valid && sync`: write capture[0], pulse `ch_strobe[0]`, set `sel`=1, go to `LOCKED`.
- **`LOCKED`:**
  - Each `din_valid` writes capture[`sel`] and pulses `ch_strobe[sel]`.
  - `sel` then increments, wrapping from `NUM_CH-1` to 0.
- **Frame completion:** on an accepted sample at `sel`==`NUM_CH-1`:
  - `dout` loads all capture registers, with the current `din` used for the last channel.
  - `frame_valid` pulses.
  - `dout` never shows a mix of two frames.
- **`din_valid` low:** `sel`, captures, `dout` and state hold; strobes are 0.
- **`sync` while `LOCKED` and `sel`==0:** confirmation only; no effect.
- **`sync` low at `sel`==0:** accepted as slot 0; `sync` is not mandatory every frame.
- **`sync` while `LOCKED` and `sel`≠0:** behaviour set by the Configuration macro.
- **Reset:** `sel`=0, `locked`=0, state `HUNT`, `dout`=0, captures=0, `frame_valid`=0, `ch_strobe`=0, `sync_err`=0.
  - Reset mid-frame drops the partial frame.
  - Reset has priority over every input on the same edge.

## Timing
- All outputs are registered.
- Sample accepted at edge N → `ch_strobe`, `sel`, `locked` valid after edge N.
- Last-slot sample at edge N → `dout`/`frame_valid` valid in cycle N+1, pulse width one cycle.
- Back-to-back frames are sustainable: with `din_valid` held high, `frame_valid` pulses every `NUM_CH` cycles.
- Lock latency: one accepted `sync` sample; slot 0 of that sample is kept, not discarded.

## Configuration
- Macro: `TDM_DEMUX_SYNC_CHECK_EN`.
- **Defined** — on `sync` at `sel`≠0 while `LOCKED`:
  - `sync_err` pulses one cycle.
  - The partial frame is discarded; no `frame_valid` for it; `dout` is unchanged.
  - The sample is written as slot 0 and `sel`=1, i.e. realignment on the same edge.
- **Undefined:**
  - `sync` is ignored while `LOCKED`; the sample goes to the current `sel`.
  - `sync_err` is tied 0.
  - No checker logic is synthesized.

## Structure
- Shared package `tdm_pkg`:
  - State enum `tdm_state_t` {`HUNT`, `LOCKED`}.
  - Default constants `TDM_NUM_CH`=4 and `TDM_DATA_W`=1, shared with the matching mux/serializer.
- One sub-module, `tdm_slot_ctr`:
  - Wrapping `SEL_W` counter with enable, synchronous load-to-value, and terminal-count flag.
  - Reused by the transmit side.
- Top holds the FSM, capture registers, frame output register and optional checker.

## Test plan
- **Reset, then hunt.** Apply reset, then drive 3 samples with `sync`=0 → `locked`=0, `ch_strobe`=0, `dout`=0.
- **Basic frame** (`NUM_CH`=4, `DATA_W`=1). `din_valid` held high, `din` 1,0,1,1 with `sync` on the first sample → `dout`=4'b1101 (ch0 in LSB), `frame_valid` one cycle after the 4th sample, `sel` sequence 1,2,3,0.
- **Gapped input.** Same data with `din_valid` low 2 cycles between each sample → identical `dout`, a single `frame_valid`, `sel` held during gaps.
- **Continuous stream.** 3 back-to-back frames (0xA, 0x5, 0xF) → `frame_valid` every 4 cycles, `dout` 4'hA→4'h5→4'hF with no intermediate value.
- **Misaligned sync** (macro defined). After 2 slots, `sync` arrives → `sync_err` one pulse, `dout` unchanged, new frame completes 3 samples later. Macro undefined: `sync_err`=0 and the frame completes on the original schedule.
- **Reset mid-frame.** Reset after slot 2 → next cycle `locked`=0, `sel`=0, `dout`=0; the following `sync` relocks cleanly.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared types and default sizing for the TDM mux/demux pair.
package tdm_pkg;

   localparam int unsigned TDM_NUM_CH = 4;
   localparam int unsigned TDM_DATA_W = 1;

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } tdm_state_t;

endpackage : tdm_pkg

// File: rtl/tdm_slot_ctr.sv
// Wrapping slot counter with enable, synchronous load and terminal-count flag.
module tdm_slot_ctr
   import tdm_pkg::*;
#(
   parameter  int unsigned NUM_CH = TDM_NUM_CH,
   localparam int unsigned SEL_W  = $clog2(NUM_CH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en_i,
   input  logic             load_i,
   input  logic [SEL_W-1:0] load_val_i,
   output logic [SEL_W-1:0] cnt_o,
   output logic             tc_c
);

   logic [SEL_W-1:0] cnt_q;
   logic [SEL_W-1:0] cnt_d;

   assign tc_c  = (cnt_q == SEL_W'(NUM_CH - 1));
   assign cnt_o = cnt_q;

   // Load wins over enable so a realignment can restart the count mid-frame.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (en_i) begin
         cnt_d = tc_c ? '0 : cnt_q + SEL_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule : tdm_slot_ctr

// File: rtl/tdm_demux.sv
// TDM receive demultiplexer: locks to frame sync and publishes whole frames.
// Optional misaligned-sync checker enabled by TDM_DEMUX_SYNC_CHECK_EN.
module tdm_demux
   import tdm_pkg::*;
#(
   parameter  int unsigned NUM_CH = TDM_NUM_CH,
   parameter  int unsigned DATA_W = TDM_DATA_W,
   localparam int unsigned SEL_W  = $clog2(NUM_CH)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [DATA_W-1:0]        din,
   input  logic                     din_valid,
   input  logic                     sync,
   output logic [NUM_CH*DATA_W-1:0] dout,
   output logic                     frame_valid,
   output logic [NUM_CH-1:0]        ch_strobe,
   output logic [SEL_W-1:0]         sel,
   output logic                     locked,
   output logic                     sync_err
);

   tdm_state_t                 state_q, state_d;
   logic [DATA_W-1:0]          capture_q [NUM_CH];
   logic [DATA_W-1:0]          capture_d [NUM_CH];
   logic [NUM_CH*DATA_W-1:0]   dout_q, dout_d;
   logic                       frame_valid_q, frame_valid_d;
   logic [NUM_CH-1:0]          ch_strobe_q, ch_strobe_d;
   logic                       ctr_en, ctr_load, ctr_tc;
   logic                       wr_en;
   logic [SEL_W-1:0]           wr_idx;
`ifdef TDM_DEMUX_SYNC_CHECK_EN
   logic                       sync_err_q, sync_err_d;
`endif

   tdm_slot_ctr #(.NUM_CH(NUM_CH)) u_slot_ctr (
      .clk        (clk),
      .reset      (reset),
      .en_i       (ctr_en),
      .load_i     (ctr_load),
      .load_val_i (SEL_W'(1)),
      .cnt_o      (sel),
      .tc_c       (ctr_tc)
   );

   always_comb begin
      state_d       = state_q;
      capture_d     = capture_q;
      dout_d        = dout_q;
      frame_valid_d = 1'b0;
      ch_strobe_d   = '0;
      ctr_en        = 1'b0;
      ctr_load      = 1'b0;
      wr_en         = 1'b0;
      wr_idx        = sel;
`ifdef TDM_DEMUX_SYNC_CHECK_EN
      sync_err_d    = 1'b0;
`endif
      case (state_q)
         HUNT: begin
            if (din_valid && sync) begin
               wr_en    = 1'b1;
               wr_idx   = '0;
               ctr_load = 1'b1;
               state_d  = LOCKED;
            end
         end
         LOCKED: begin
            if (din_valid) begin
`ifdef TDM_DEMUX_SYNC_CHECK_EN
               // Early sync: drop the partial frame and restart at slot 0.
               if (sync && (sel != '0)) begin
                  sync_err_d = 1'b1;
                  wr_en      = 1'b1;
                  wr_idx     = '0;
                  ctr_load   = 1'b1;
               end else
`endif
               begin
                  wr_en  = 1'b1;
                  ctr_en = 1'b1;
                  // Last slot bypasses its capture so the frame publishes on this edge.
                  if (ctr_tc) begin
                     frame_valid_d = 1'b1;
                     for (int unsigned k = 0; k < NUM_CH; k++) begin
                        dout_d[k*DATA_W +: DATA_W] = (k == NUM_CH - 1) ? din : capture_q[k];
                     end
                  end
               end
            end
         end
      endcase
      if (wr_en) begin
         capture_d[wr_idx] = din;
         ch_strobe_d       = NUM_CH'(1) << wr_idx;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= HUNT;
         capture_q     <= '{default: '0};
         dout_q        <= '0;
         frame_valid_q <= 1'b0;
         ch_strobe_q   <= '0;
      end else begin
         state_q       <= state_d;
         capture_q     <= capture_d;
         dout_q        <= dout_d;
         frame_valid_q <= frame_valid_d;
         ch_strobe_q   <= ch_strobe_d;
      end
   end

`ifdef TDM_DEMUX_SYNC_CHECK_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_err_q <= 1'b0;
      end else begin
         sync_err_q <= sync_err_d;
      end
   end
   assign sync_err = sync_err_q;
`else
   assign sync_err = 1'b0;
`endif

   assign dout        = dout_q;
   assign frame_valid = frame_valid_q;
   assign ch_strobe   = ch_strobe_q;
   assign locked      = (state_q == LOCKED);

endmodule : tdm_demux

// File: tb/tb_tdm_demux.sv
// Self-checking bench for tdm_demux (NUM_CH=4, DATA_W=1): vector table,
// directed corner sequences and random traffic against a frame-level model.
module tb_tdm_demux;

   localparam int unsigned NCH = 4;
   localparam int unsigned DW  = 1;
`ifdef TDM_DEMUX_SYNC_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [0:0] din = '0;
   logic       din_valid = 1'b0;
   logic       sync = 1'b0;
   logic [3:0] dout;
   logic       frame_valid;
   logic [3:0] ch_strobe;
   logic [1:0] sel;
   logic       locked;
   logic       sync_err;

   tdm_demux #(.NUM_CH(NCH), .DATA_W(DW)) dut (
      .clk         (clk),
      .reset       (reset),
      .din         (din),
      .din_valid   (din_valid),
      .sync        (sync),
      .dout        (dout),
      .frame_valid (frame_valid),
      .ch_strobe   (ch_strobe),
      .sel         (sel),
      .locked      (locked),
      .sync_err    (sync_err)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Frame-level reference: slot position, partial frame bits, last published frame.
   bit         m_locked;
   int         m_slot;
   logic [3:0] m_part;
   logic [3:0] m_dout;
   logic       m_fv;
   logic       m_err;
   logic [3:0] m_strb;

   typedef struct {
      logic       r, v, s, d;
      logic [3:0] e_dout;
      logic       e_fv;
      logic [3:0] e_strb;
      logic [1:0] e_sel;
      logic       e_lock;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
      end
   endtask

   task automatic model(input logic r, input logic v, input logic s, input logic d);
      m_fv = 1'b0; m_err = 1'b0; m_strb = '0;
      if (r) begin
         m_locked = 1'b0; m_slot = 0; m_part = '0; m_dout = '0;
      end else if (v) begin
         if (!m_locked) begin
            if (s) begin
               m_part[0] = d; m_strb = 4'b0001; m_slot = 1; m_locked = 1'b1;
            end
         end else if (CHK && s && m_slot != 0) begin
            m_err = 1'b1; m_part[0] = d; m_strb = 4'b0001; m_slot = 1;
         end else begin
            m_part[m_slot] = d;
            m_strb = 4'(1 << m_slot);
            if (m_slot == NCH - 1) begin
               m_dout = m_part; m_fv = 1'b1;
            end
            m_slot = (m_slot + 1) % NCH;
         end
      end
   endtask

   task automatic step(input logic r, input logic v, input logic s, input logic d);
      @(negedge clk);
      reset = r; din_valid = v; sync = s; din = d;
      model(r, v, s, d);
      @(posedge clk);
      #1;
      chk("dout",        32'(dout),        32'(m_dout));
      chk("frame_valid", 32'(frame_valid), 32'(m_fv));
      chk("ch_strobe",   32'(ch_strobe),   32'(m_strb));
      chk("sel",         32'(sel),         32'(m_slot));
      chk("locked",      32'(locked),      32'(m_locked));
      chk("sync_err",    32'(sync_err),    32'(m_err));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] frames [3];
      logic [3:0] seen [$];
      logic [3:0] prev;
      logic [3:0] bits;
      int         fv_cnt, fv_at, stray, last_fv, bad_gap, cyc;

      // reset, hunt with no sync, then the basic 1,0,1,1 frame
      tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 2'd0, 1'b0});
      for (int i = 0; i < 3; i++)
         tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 4'h0, 2'd0, 1'b0});
      tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 1'b0, 4'b0001, 2'd1, 1'b1});
      tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'b0010, 2'd2, 1'b1});
      tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 4'b0100, 2'd3, 1'b1});
      tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 4'hD, 1'b1, 4'b1000, 2'd0, 1'b1});
      tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 4'hD, 1'b0, 4'h0, 2'd0, 1'b1});

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].r, tbl[i].v, tbl[i].s, tbl[i].d);
         chk("tbl_dout",   32'(dout),        32'(tbl[i].e_dout));
         chk("tbl_fv",     32'(frame_valid), 32'(tbl[i].e_fv));
         chk("tbl_strobe", 32'(ch_strobe),   32'(tbl[i].e_strb));
         chk("tbl_sel",    32'(sel),         32'(tbl[i].e_sel));
         chk("tbl_locked", 32'(locked),      32'(tbl[i].e_lock));
         chk("tbl_err",    32'(sync_err),    32'(1'b0));
      end

      // gapped input: two idle cycles between samples
      step(1'b1, 1'b0, 1'b0, 1'b0);
      bits = 4'b1101; fv_cnt = 0;
      for (int i = 0; i < NCH; i++) begin
         step(1'b0, 1'b1, (i == 0), bits[i]);
         fv_cnt += int'(frame_valid);
         for (int g = 0; g < 2; g++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1);
            fv_cnt += int'(frame_valid);
         end
      end
      chk("gap_dout",   32'(dout), 32'h0000_000D);
      chk("gap_fv_cnt", 32'(fv_cnt), 32'd1);

      // continuous stream of three frames
      step(1'b1, 1'b0, 1'b0, 1'b0);
      frames[0] = 4'hA; frames[1] = 4'h5; frames[2] = 4'hF;
      prev = dout; stray = 0; last_fv = -1; bad_gap = 0; cyc = 0;
      for (int f = 0; f < 3; f++) begin
         for (int i = 0; i < NCH; i++) begin
            bits = frames[f];
            step(1'b0, 1'b1, (f == 0 && i == 0), bits[i]);
            cyc++;
            if (dout !== prev && !frame_valid) stray++;
            if (frame_valid) begin
               seen.push_back(dout);
               if (last_fv >= 0 && cyc - last_fv != NCH) bad_gap++;
               last_fv = cyc;
            end
            prev = dout;
         end
      end
      chk("stream_fv_cnt", 32'(seen.size()), 32'd3);
      chk("stream_stray",  32'(stray), 32'd0);
      chk("stream_gap",    32'(bad_gap), 32'd0);
      for (int f = 0; f < 3 && f < seen.size(); f++)
         chk("stream_dout", 32'(seen[f]), 32'(frames[f]));

      // misaligned sync after two slots, then three more samples
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b1);
      chk("mis_err",  32'(sync_err), 32'(CHK));
      chk("mis_sel",  32'(sel), CHK ? 32'd1 : 32'd3);
      chk("mis_dout", 32'(dout), 32'h0);
      bits = 4'b1100; fv_at = -1;
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 1'b0, bits[i + 1]);
         if (frame_valid) begin
            if (fv_at < 0) fv_at = i;
            chk("mis_frame", 32'(dout), CHK ? 32'hD : 32'h5);
         end
      end
      chk("mis_fv_at", 32'(fv_at), CHK ? 32'd2 : 32'd0);

      // reset mid-frame, then relock
      step(1'b0, 1'b1, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b1, 1'b1);
      chk("rst_locked", 32'(locked), 32'd0);
      chk("rst_sel",    32'(sel), 32'd0);
      chk("rst_dout",   32'(dout), 32'd0);
      bits = 4'b0110;
      for (int i = 0; i < NCH; i++) step(1'b0, 1'b1, (i == 0), bits[i]);
      chk("relock_fv",   32'(frame_valid), 32'd1);
      chk("relock_dout", 32'(dout), 32'h6);

      // random traffic against the model
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 60) == 0), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 5) == 0), 1'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_tdm_demux
